// File: rtl/rx_pkg.sv
// Shared types for the RX capture path: sample format codes and the
// capture sequencer state encoding.
package rx_pkg;

    // Sample format carried on data_format to the FIFO stage.
    typedef enum logic [2:0] {
        C64 = 3'd0,
        R64 = 3'd1,
        C32 = 3'd2,
        R32 = 3'd3,
        C16 = 3'd4,
        R16 = 3'd5,
        C8  = 3'd6,
        R8  = 3'd7
    } rx_fmt_t;

    // Capture sequencer states.
    typedef enum logic [2:0] {
        CAP_IDLE  = 3'd0,
        CAP_FLUSH = 3'd1,
        CAP_ARM   = 3'd2,
        CAP_RUN   = 3'd3,
        CAP_STOP  = 3'd4,
        CAP_DONE  = 3'd5
    } rx_cap_state_t;

    // Format presented to the FIFO stage out of reset (16-bit complex).
    localparam rx_fmt_t RX_FMT_DEFAULT = C16;

endpackage

// File: rtl/rx_capture_ctrl.sv
// RX capture sequencer. Flushes the RX FIFO, arms the writer, forwards a
// counted burst of AXIS beats (tlast on the final one), then disarms and
// flushes again. Reports beat count, overflow and abort status.
module rx_capture_ctrl
    import rx_pkg::*;
#(
    parameter int DATA_W        = 128,
    parameter int LEN_W         = 32,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_format,
    input  logic [LEN_W-1:0]  cmd_beats,
    input  logic              cmd_abort,
    output logic              rx_enable,
    output logic [2:0]        data_format,
    input  logic              fifo_rd_rst_busy,
    input  logic              fifo_prog_full,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              aborted,
    output logic [LEN_W-1:0]  beat_count
);

    // Settle counter counts 0..SETTLE_LAST and then holds.
    localparam int SETTLE_LAST = (SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 1 : 0;
    localparam int CNT_W       = (SETTLE_LAST > 0) ? $clog2(SETTLE_LAST + 1) : 1;

    rx_cap_state_t    state;
    logic [CNT_W-1:0] settle_cnt;
    logic [LEN_W-1:0] len_q;       // latched command length, 0 = continuous
    logic             settle_done;
    logic             in_run;
    logic             beat;

    assign settle_done = (settle_cnt == CNT_W'(SETTLE_LAST));

    // Zero-latency data path in RUN; FLUSH and STOP sink stale beats.
    always_comb begin
        in_run        = (state == CAP_RUN);
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = in_run && s_axis_tvalid;
        s_axis_tready = in_run ? m_axis_tready
                               : ((state == CAP_FLUSH) || (state == CAP_STOP));
        // tlast is decoded from registered count, so it is valid before the handshake.
        m_axis_tlast  = in_run && (len_q != '0) && (beat_count == len_q - LEN_W'(1));
        beat          = m_axis_tvalid && m_axis_tready;
    end

    // Sequencer: state, settle counter, status and all registered control outputs.
    // NOTE: every register here uses non-blocking assignment so that all the
    // decisions in one cycle see the same pre-edge values of state and counters.
    always_ff @(posedge aclk or negedge aresetn) begin
        // NOTE: the asynchronous reset must drop rx_enable immediately, without
        // waiting for a clock edge, so the FIFO writer is disarmed at once.
        if (!aresetn) begin
            state       <= CAP_IDLE;
            settle_cnt  <= '0;
            len_q       <= '0;
            rx_enable   <= 1'b0;
            data_format <= RX_FMT_DEFAULT;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            aborted     <= 1'b0;
            beat_count  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                CAP_IDLE: begin
                    if (cmd_valid) begin
                        data_format <= cmd_format;
                        len_q       <= cmd_beats;
                        beat_count  <= '0;
                        overflow    <= 1'b0;
                        aborted     <= 1'b0;
                        settle_cnt  <= '0;
                        cmd_ready   <= 1'b0;
                        busy        <= 1'b1;
                        state       <= CAP_FLUSH;
                    end
                end

                CAP_FLUSH: begin
                    if (cmd_abort) begin
                        aborted    <= 1'b1;
                        rx_enable  <= 1'b0;
                        settle_cnt <= '0;
                        state      <= CAP_STOP;
                    end else if (settle_done && !fifo_rd_rst_busy) begin
                        rx_enable <= 1'b1;
                        state     <= CAP_ARM;
                    end else if (!settle_done) begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end

                CAP_ARM: begin
                    if (cmd_abort) begin
                        aborted    <= 1'b1;
                        rx_enable  <= 1'b0;
                        settle_cnt <= '0;
                        state      <= CAP_STOP;
                    end else if (!fifo_rd_rst_busy) begin
                        state <= CAP_RUN;
                    end
                end

                CAP_RUN: begin
                    if (beat && (beat_count != '1)) begin
                        beat_count <= beat_count + LEN_W'(1);
                    end
                    if (fifo_prog_full) begin
                        overflow <= 1'b1;
                    end
                    // A beat in the abort cycle is still forwarded and counted above.
                    if (cmd_abort || (beat && m_axis_tlast)) begin
                        if (cmd_abort) begin
                            aborted <= 1'b1;
                        end
                        rx_enable  <= 1'b0;
                        settle_cnt <= '0;
                        state      <= CAP_STOP;
                    end
                end

                CAP_STOP: begin
                    if (settle_done && !fifo_rd_rst_busy) begin
                        done  <= 1'b1;
                        state <= CAP_DONE;
                    end else if (!settle_done) begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end

                CAP_DONE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= CAP_IDLE;
                end

                default: begin
                    rx_enable <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= CAP_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_capture_ctrl.sv
// Self-checking bench for rx_capture_ctrl. A random AXIS source and sink run
// each cycle; a scoreboard expects every source beat accepted while the
// writer is armed to appear downstream in order, with tlast on beat N of N.
module tb_rx_capture_ctrl;
    import rx_pkg::*;

    localparam int DATA_W = 128;
    localparam int LEN_W  = 32;
    localparam int SETTLE = 16;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_format;
    logic [LEN_W-1:0]  cmd_beats;
    logic              cmd_abort;
    logic              rx_enable;
    logic [2:0]        data_format;
    logic              fifo_rd_rst_busy;
    logic              fifo_prog_full;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic              busy;
    logic              done;
    logic              overflow;
    logic              aborted;
    logic [LEN_W-1:0]  beat_count;

    rx_capture_ctrl #(
        .DATA_W        (DATA_W),
        .LEN_W         (LEN_W),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_format       (cmd_format),
        .cmd_beats        (cmd_beats),
        .cmd_abort        (cmd_abort),
        .rx_enable        (rx_enable),
        .data_format      (data_format),
        .fifo_rd_rst_busy (fifo_rd_rst_busy),
        .fifo_prog_full   (fifo_prog_full),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tlast     (m_axis_tlast),
        .busy             (busy),
        .done             (done),
        .overflow         (overflow),
        .aborted          (aborted),
        .beat_count       (beat_count)
    );

    always #5 aclk = ~aclk;

    // Counters and reference-model state.
    int                n_cmp = 0;
    int                n_err = 0;
    int                cyc = 0;
    logic [DATA_W-1:0] exp_q[$];
    int                acc_cyc = 0;
    int                rise_cyc = 0;
    int                fall_cyc = 0;
    int                done_cyc = 0;
    int                done_cnt = 0;
    int                tlast_cnt = 0;
    int                beats_seen = 0;
    logic [LEN_W-1:0]  cur_len = '0;
    logic              prev_en = 1'b0;
    bit                src_always = 1'b1;
    bit                sink_random = 1'b0;
    bit                sink_force = 1'b0;
    bit                chk_mirror = 1'b0;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One clock: observe at the falling edge, then drive new inputs just after the rising edge.
    task automatic cycle();
        logic              hs_s;
        logic              hs_m;
        logic              exp_last;
        logic [DATA_W-1:0] exp_d;
        @(negedge aclk);
        hs_s = s_axis_tvalid && s_axis_tready;
        hs_m = m_axis_tvalid && m_axis_tready;
        if (cmd_valid && cmd_ready) begin
            acc_cyc    = cyc;
            cur_len    = cmd_beats;
            beats_seen = 0;
            done_cnt   = 0;
            tlast_cnt  = 0;
        end
        if (rx_enable && !prev_en) rise_cyc = cyc;
        if (!rx_enable && prev_en) fall_cyc = cyc;
        prev_en = rx_enable;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (chk_mirror && m_axis_tvalid) check("mirror_tready", s_axis_tready, m_axis_tready);
        if (hs_s && rx_enable) exp_q.push_back(s_axis_tdata);
        if (hs_m) begin
            check("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                exp_d = exp_q.pop_front();
                check("beat_data", m_axis_tdata, exp_d);
            end
            exp_last = (cur_len != 0) && (beats_seen + 1 == cur_len);
            check("tlast", m_axis_tlast, exp_last);
            if (m_axis_tlast) tlast_cnt++;
            beats_seen++;
        end
        @(posedge aclk);
        cyc++;
        #1;
        if (hs_s || !s_axis_tvalid) begin
            s_axis_tdata  = rand_word();
            s_axis_tvalid = src_always ? 1'b1 : ($urandom_range(3) != 0);
        end
        if (!sink_force) m_axis_tready = sink_random ? 1'($urandom_range(1)) : 1'b1;
    endtask

    task automatic start_cmd(input logic [2:0] fmt, input int beats);
        cmd_format = fmt;
        cmd_beats  = beats;
        cmd_valid  = 1'b1;
        check("cmd_ready_idle", cmd_ready, 1);
        cycle();
        cmd_valid = 1'b0;
        check("fmt_latched", data_format, fmt);
        check("busy_set", busy, 1);
        check("cmd_ready_low", cmd_ready, 0);
        check("ovf_cleared", overflow, 0);
        check("abort_cleared", aborted, 0);
        check("count_cleared", beat_count, 0);
    endtask

    // Wait for the done pulse (bounded) and check the end-of-capture state.
    // exp_count < 0 means the expected count is whatever the scoreboard saw.
    task automatic finish_capture(input int exp_count, input logic exp_abort,
                                  input logic exp_ovf, input int exp_tlast);
        int n;
        int want;
        n = 0;
        while (done_cnt == 0 && n < 2000) begin
            cycle();
            n++;
        end
        check("done_seen", done_cnt != 0, 1);
        repeat (3) cycle();
        want = (exp_count < 0) ? beats_seen : exp_count;
        if (exp_count >= 0) check("model_beats", beats_seen, exp_count);
        check("done_single", done_cnt, 1);
        check("beat_count", beat_count, want);
        check("aborted", aborted, exp_abort);
        check("overflow", overflow, exp_ovf);
        check("tlast_count", tlast_cnt, exp_tlast);
        check("rx_enable_off", rx_enable, 0);
        check("idle_ready", cmd_ready, 1);
        check("idle_busy", busy, 0);
        check("queue_drained", exp_q.size(), 0);
        check("settle_arm", (rise_cyc - acc_cyc) >= SETTLE + 1, 1);
        check("settle_stop", (done_cyc - fall_cyc) >= SETTLE, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_enable"}, rx_enable, 0);
        check({tag, "_format"}, data_format, 3'd4);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_aborted"}, aborted, 0);
        check({tag, "_beat_count"}, beat_count, 0);
        check({tag, "_m_tvalid"}, m_axis_tvalid, 0);
        check({tag, "_m_tlast"}, m_axis_tlast, 0);
        check({tag, "_s_tready"}, s_axis_tready, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int drop_cyc;
        aresetn          = 1'b0;
        cmd_valid        = 1'b0;
        cmd_format       = 3'd0;
        cmd_beats        = '0;
        cmd_abort        = 1'b0;
        fifo_rd_rst_busy = 1'b0;
        fifo_prog_full   = 1'b0;
        s_axis_tdata     = '0;
        s_axis_tvalid    = 1'b0;
        m_axis_tready    = 1'b1;

        // Reset state.
        #12;
        check_reset_values("reset");
        @(posedge aclk);
        #1 aresetn = 1'b1;

        // Abort while idle is ignored.
        cmd_abort = 1'b1;
        cycle();
        cmd_abort = 1'b0;
        check("idle_abort_ignored", aborted, 0);
        check("idle_abort_busy", busy, 0);

        // Fixed-length capture, sink always ready, source streaming.
        src_always  = 1'b1;
        sink_random = 1'b0;
        start_cmd(3'd4, 8);
        finish_capture(8, 1'b0, 1'b0, 1);

        // Short capture with a randomly stalling sink and bursty source.
        src_always  = 1'b0;
        sink_random = 1'b1;
        chk_mirror  = 1'b1;
        start_cmd(3'($urandom_range(7)), 4);
        finish_capture(4, 1'b0, 1'b0, 1);
        chk_mirror  = 1'b0;

        // Continuous capture aborted after exactly 100 beats (no beat in the abort cycle).
        src_always  = 1'b1;
        sink_random = 1'b0;
        start_cmd(3'd2, 0);
        n = 0;
        while (beats_seen < 100 && n < 1000) begin
            cycle();
            n++;
        end
        check("reach_100", beats_seen, 100);
        sink_force    = 1'b1;
        m_axis_tready = 1'b0;
        cmd_abort     = 1'b1;
        cycle();
        cmd_abort  = 1'b0;
        sink_force = 1'b0;
        finish_capture(100, 1'b1, 1'b0, 0);

        // One-cycle prog_full mid-RUN sets sticky overflow; random flow control.
        src_always  = 1'b0;
        sink_random = 1'b1;
        start_cmd(3'd7, 0);
        n = 0;
        while (beats_seen < 10 && n < 1000) begin
            cycle();
            n++;
        end
        check("ovf_before_pulse", overflow, 0);
        fifo_prog_full = 1'b1;
        cycle();
        fifo_prog_full = 1'b0;
        check("ovf_set", overflow, 1);
        repeat (5) cycle();
        check("ovf_sticky", overflow, 1);
        cmd_abort = 1'b1;
        cycle();
        cmd_abort = 1'b0;
        finish_capture(-1, 1'b1, 1'b1, 0);

        // Read-reset busy held through FLUSH; single-beat command carries tlast.
        src_always       = 1'b1;
        sink_random      = 1'b0;
        fifo_rd_rst_busy = 1'b1;
        start_cmd(3'd5, 1);
        repeat (40) cycle();
        check("arm_held_by_busy", rx_enable, 0);
        drop_cyc         = cyc;
        fifo_rd_rst_busy = 1'b0;
        finish_capture(1, 1'b0, 1'b0, 1);
        check("arm_after_busy", rise_cyc > drop_cyc, 1);

        // Abort coinciding with the final beat: beat carries tlast, aborted set.
        start_cmd(3'd1, 3);
        n = 0;
        while (beats_seen < 2 && n < 1000) begin
            cycle();
            n++;
        end
        check("reach_2", beats_seen, 2);
        sink_force    = 1'b1;
        m_axis_tready = 1'b1;
        cmd_abort     = 1'b1;
        cycle();
        cmd_abort  = 1'b0;
        sink_force = 1'b0;
        finish_capture(3, 1'b1, 1'b0, 1);

        // Reset asserted mid-RUN forces outputs to reset values without a clock edge.
        start_cmd(3'd0, 0);
        repeat (25) cycle();
        check("running_before_reset", rx_enable, 1);
        #2 aresetn = 1'b0;
        #1;
        check_reset_values("midrun_reset");
        @(negedge aclk);
        aresetn = 1'b1;
        exp_q.delete();
        prev_en = 1'b0;
        repeat (2) cycle();
        check("post_reset_ready", cmd_ready, 1);
        check("post_reset_enable", rx_enable, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
